// File: rtl/aes_pkg.sv
// Shared types, S-box table and byte/word helpers for the AES key-schedule engine.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_blk_t;

  typedef enum logic [1:0] {
    KeyLen128 = 2'b00,
    KeyLen192 = 2'b01,
    KeyLen256 = 2'b10,
    KeyLenBad = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } kx_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: applies the AES S-box to each byte of a 32-bit word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign dout[8*b +: 8] = SBOX[din[8*b +: 8]];
  end

endmodule

// File: rtl/aes_key_expand_iter.sv
// Iterative AES-128/192/256 key expansion, one word per cycle, with a registered round-key port.
// Optional AES_KEY_ZEROIZE_EN adds a zeroize input that wipes all key material.
module aes_key_expand_iter
  import aes_pkg::*;
#(
  parameter int unsigned MAX_NK   = 8,
  parameter int unsigned RD_IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                  zeroize,
`endif
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            nr,
  output logic [3:0]            rk_avail,
  input  logic                  rd_en,
  input  logic [RD_IDX_W-1:0]   rd_round,
  output logic [127:0]          rd_key,
  output logic                  rd_valid
);

  localparam int unsigned Words = 4 * (MAX_NK + 7);
  localparam int unsigned IdxW  = $clog2(Words);

  kx_state_e       state_q, state_d;
  aes_word_t       buf_q [Words];
  aes_word_t       prev_q;
  logic [IdxW-1:0] i_q;
  logic [2:0]      kmod_q;
  logic [3:0]      nk_q, nr_q, rk_avail_q;
  logic [7:0]      rcon_q;
  logic            err_q, rd_valid_q;
  aes_blk_t        rd_key_q;
  logic            zero_req;

`ifdef AES_KEY_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  // Job decode: an Nk of zero marks the illegal encoding.
  logic [3:0] nk_sel;
  logic       accept, load, reject;
  always_comb begin
    unique case (key_len_e'(key_len))
      KeyLen128: nk_sel = 4'd4;
      KeyLen192: nk_sel = 4'd6;
      KeyLen256: nk_sel = 4'd8;
      default:   nk_sel = 4'd0;
    endcase
  end
  assign accept = start && (nk_sel != 4'd0) && (32'(nk_sel) <= MAX_NK);
  assign load   = (state_q == StIdle) && accept;
  assign reject = (state_q == StIdle) && start && !accept;

  aes_word_t key_last;
  always_comb begin
    key_last = '0;
    for (int k = 0; k < int'(MAX_NK); k++) begin
      if (32'(nk_sel) == 32'(k + 1)) key_last = key[32*(int'(MAX_NK)-k)-1 -: 32];
    end
  end

  // Expansion datapath; the single S-box serves both SubWord cases.
  aes_word_t sub_in, sub_out, temp, w_new;
  logic      last;
  assign sub_in = (kmod_q == 3'd0) ? rot_word(prev_q) : prev_q;

  aes_sbox_word u_sbox (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    temp = prev_q;
    if (kmod_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && kmod_q == 3'd4) begin
      temp = sub_out;
    end
  end
  assign w_new = buf_q[i_q - IdxW'(nk_q)] ^ temp;
  assign last  = (i_q == IdxW'(32'(nr_q) * 4 + 3));

  // Read port decode
  logic            rd_hit;
  logic [IdxW-1:0] rd_base;
  aes_blk_t        rd_blk;
  assign rd_hit  = 32'(rd_round) < 32'(rk_avail_q);
  assign rd_base = IdxW'(32'(rd_round) * 4);
  assign rd_blk  = {buf_q[rd_base], buf_q[rd_base + IdxW'(1)],
                    buf_q[rd_base + IdxW'(2)], buf_q[rd_base + IdxW'(3)]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (load) state_d = StExpand;
      StExpand: if (last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (zero_req) state_d = StIdle;
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      StIdle:   ready = 1'b1;
      StExpand: busy  = 1'b1;
      StDone:   done  = 1'b1;
      default:  ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(Words); k++) buf_q[k] <= '0;
      prev_q     <= '0;
      i_q        <= '0;
      kmod_q     <= '0;
      nk_q       <= 4'd4;
      nr_q       <= 4'd10;
      rk_avail_q <= '0;
      rcon_q     <= 8'h01;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
    end else if (zero_req) begin
      for (int k = 0; k < int'(Words); k++) buf_q[k] <= '0;
      prev_q     <= '0;
      rk_avail_q <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      err_q <= reject;
      if (load) begin
        for (int k = 0; k < int'(MAX_NK); k++) begin
          if (k < int'(nk_sel)) buf_q[k] <= key[32*(int'(MAX_NK)-k)-1 -: 32];
        end
        prev_q     <= key_last;
        nk_q       <= nk_sel;
        nr_q       <= nk_sel + 4'd6;
        i_q        <= IdxW'(nk_sel);
        kmod_q     <= '0;
        rcon_q     <= 8'h01;
        rk_avail_q <= nk_sel >> 2;
      end else if (state_q == StExpand) begin
        buf_q[i_q] <= w_new;
        prev_q     <= w_new;
        i_q        <= i_q + IdxW'(1);
        kmod_q     <= (kmod_q == 3'(nk_q - 4'd1)) ? 3'd0 : kmod_q + 3'd1;
        if (kmod_q == 3'd0) rcon_q <= xtime(rcon_q);
        rk_avail_q <= 4'((32'(i_q) + 1) >> 2);
      end
      if (rd_en) begin
        rd_valid_q <= rd_hit;
        rd_key_q   <= rd_hit ? rd_blk : '0;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign err      = err_q;
  assign nr       = nr_q;
  assign rk_avail = rk_avail_q;
  assign rd_key   = rd_key_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_aes_key_expand_iter.sv
// Self-checking bench for aes_key_expand_iter: known-answer vectors plus random keys against
// a FIPS-197 style reference built from GF(2^8) arithmetic.
module tb_aes_key_expand_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [255:0] key = '0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_round = '0;
  logic         ready, busy, done, err, rd_valid;
  logic [3:0]   nr, rk_avail;
  logic [127:0] rd_key;
`ifdef AES_KEY_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0]  sbox [256];
  logic [31:0] mw [60];

  always #5 clk = ~clk;

  aes_key_expand_iter #(.MAX_NK(8), .RD_IDX_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize  (zeroize),
`endif
    .start    (start),
    .key_len  (key_len),
    .key      (key),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .nr       (nr),
    .rk_avail (rk_avail),
    .rd_en    (rd_en),
    .rd_round (rd_round),
    .rd_key   (rd_key),
    .rd_valid (rd_valid)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    d = d << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [255:0] k, input int nk);
    int total = 4 * (nk + 7);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int r, output logic [127:0] k, output logic v);
    rd_en = 1'b1;
    rd_round = 4'(r);
    tick();
    rd_en = 1'b0;
    k = rd_key;
    v = rd_valid;
  endtask

  task automatic start_job(input logic [1:0] len, input logic [255:0] k);
    start = 1'b1;
    key_len = len;
    key = k;
    tick();
    start = 1'b0;
  endtask

  // Cycle 1 is the cycle start is presented; returns the cycle in which done is seen.
  task automatic wait_done(output int cyc);
    cyc = 2;
    while (done !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_rounds(input string tag, input int nrr);
    logic [127:0] k;
    logic v;
    for (int r = 0; r <= nrr; r++) begin
      do_read(r, k, v);
      chk({tag, "_valid"}, 128'(v), 128'(1));
      chk({tag, "_key"}, k, model_rk(r));
    end
    do_read(nrr + 1, k, v);
    chk({tag, "_oob_valid"}, 128'(v), 128'(0));
    chk({tag, "_oob_key"}, k, 128'(0));
  endtask

  task automatic run_check(input string tag, input logic [1:0] len, input logic [255:0] k);
    int nk = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
    int nrr = nk + 6;
    int cyc;
    model_expand(k, nk);
    start_job(len, k);
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    chk({tag, "_avail0"}, 128'(rk_avail), 128'(nk / 4));
    chk({tag, "_nr"}, 128'(nr), 128'(nrr));
    wait_done(cyc);
    chk({tag, "_latency"}, 128'(cyc), 128'(1 + (4 * (nrr + 1) - nk) + 1));
    tick();
    chk({tag, "_done_pulse"}, 128'(done), 128'(0));
    chk({tag, "_ready"}, 128'(ready), 128'(1));
    chk({tag, "_avail_end"}, 128'(rk_avail), 128'(nrr + 1));
    check_rounds(tag, nrr);
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  initial begin
    logic [127:0] k;
    logic v;
    logic [255:0] rk;
    int cnt;

    build_sbox();

    tick();
    tick();
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_rd_key", rd_key, 128'(0));
    chk("rst_avail", 128'(rk_avail), 128'(0));
    chk("rst_nr", 128'(nr), 128'(10));
    rst = 1'b1;
    tick();
    do_read(0, k, v);
    chk("idle_read_valid", 128'(v), 128'(0));

    // Known-answer vectors; the unused key LSBs carry junk that must be ignored.
    run_check("kat128", 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_0badc0de_12345678});
    do_read(1, k, v);
    chk("kat128_r1", k, 128'ha0fafe1788542cb123a339392a6c7605);
    do_read(10, k, v);
    chk("kat128_r10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    do_read(11, k, v);
    chk("kat128_r11_valid", 128'(v), 128'(0));
    chk("kat128_r11_key", k, 128'(0));

    run_check("kat192", 2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffff_ffffffff});
    do_read(12, k, v);
    chk("kat192_r12", k, 128'he98ba06f448c773c8ecc720401002202);

    run_check("kat256", 2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    do_read(14, k, v);
    chk("kat256_r14", k, 128'hfe4890d1e6188d0b046df344706c631e);

    for (int rep = 0; rep < 2; rep++) begin
      run_check("rnd128", 2'b00, rand_key());
      run_check("rnd192", 2'b01, rand_key());
      run_check("rnd256", 2'b10, rand_key());
    end

    // Early read while expanding, then a start that must be ignored mid-job.
    rk = rand_key();
    model_expand(rk, 4);
    start_job(2'b00, rk);
    cnt = 0;
    while (rk_avail !== 4'd4 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("early_avail", 128'(rk_avail), 128'(4));
    do_read(3, k, v);
    chk("early_r3_valid", 128'(v), 128'(1));
    chk("early_r3_key", k, model_rk(3));
    do_read(4, k, v);
    chk("early_r4_valid", 128'(v), 128'(0));
    chk("early_r4_key", k, 128'(0));
    start_job(2'b10, rand_key());
    chk("busy_start_err", 128'(err), 128'(0));
    chk("busy_start_busy", 128'(busy), 128'(1));
    wait_done(cnt);
    tick();
    chk("busy_start_nr", 128'(nr), 128'(10));
    chk("busy_start_avail", 128'(rk_avail), 128'(11));
    check_rounds("busy_start", 10);

    // Illegal key length leaves previous job intact.
    start_job(2'b11, rand_key());
    chk("bad_err", 128'(err), 128'(1));
    chk("bad_ready", 128'(ready), 128'(1));
    chk("bad_avail", 128'(rk_avail), 128'(11));
    tick();
    chk("bad_err_pulse", 128'(err), 128'(0));
    do_read(10, k, v);
    chk("bad_r10_key", k, model_rk(10));

    // Reset after 20 words of an AES-192 job.
    start_job(2'b01, rand_key());
    for (int n = 0; n < 14; n++) tick();
    chk("mid_avail", 128'(rk_avail), 128'(5));
    rst = 1'b0;
    tick();
    chk("mid_rst_ready", 128'(ready), 128'(1));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_avail", 128'(rk_avail), 128'(0));
    chk("mid_rst_nr", 128'(nr), 128'(10));
    chk("mid_rst_rd_key", rd_key, 128'(0));
    rst = 1'b1;
    tick();
    chk("mid_rst_done", 128'(done), 128'(0));
    for (int r = 0; r < 4; r++) begin
      do_read(r, k, v);
      chk("mid_rst_read_valid", 128'(v), 128'(0));
      chk("mid_rst_read_key", k, 128'(0));
    end

`ifdef AES_KEY_ZEROIZE_EN
    run_check("zpre", 2'b00, rand_key());
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("zero_avail", 128'(rk_avail), 128'(0));
    chk("zero_ready", 128'(ready), 128'(1));
    chk("zero_rd_key", rd_key, 128'(0));
    do_read(0, k, v);
    chk("zero_r0_valid", 128'(v), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_iter.md
Name: aes_key_expand_iter

Overview:
Iterative AES key-schedule engine supporting AES-128, AES-192 and AES-256, selected per job at run time.
Expands the cipher key one 32-bit word per cycle into an internal round-key buffer of up to 60 words.
Serves 128-bit round keys through a registered read port to the cipher datapath.
Publishes a running count of completed round keys so a pipelined cipher can start before expansion finishes.

Parameters:
MAX_NK, 8, largest key length in words; legal values 4, 6, 8; sizes the buffer to 4*(MAX_NK+7) words.
RD_IDX_W, 4, width of the round index on the read port.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
start  in  1  job request; accepted only while ready=1
key_len  in  2  key length: 00=128, 01=192, 10=256, 11=illegal
key  in  32*MAX_NK  cipher key, left-aligned (w0 = MSBs); unused LSBs ignored
ready  out  1  idle, can accept start
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when the last word is written
err  out  1  one-cycle pulse when start is rejected
nr  out  4  round count of the current/last job: 10, 12 or 14
rk_avail  out  4  number of complete round keys in the buffer, 0..Nr+1 (0 while idle with no job)
rd_en  in  1  read request
rd_round  in  RD_IDX_W  round key index
rd_key  out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}; 1-cycle latency
rd_valid  out  1  high the cycle after rd_en when the round was complete at request time

Behaviour:
- Reset (rst=0 at an edge): state IDLE; ready=1; busy=done=err=rd_valid=0; rd_key=0; rk_avail=0; nr=10; buffer cleared; rcon=8'h01.
- States are IDLE, EXPAND, DONE.
- IDLE:
  - start=1 with key_len!=11: latch Nk (4/6/8) and Nr (10/12/14); write w0..w(Nk-1) into the buffer in the same edge; load prev=w(Nk-1); set i=Nk, rcon=01; go to EXPAND.
  - start=1 with key_len=11: stay in IDLE, pulse err for one cycle; buffer and rk_avail are unchanged.
  - If Nk exceeds MAX_NK, the start is rejected the same way.
- EXPAND, each cycle:
  - temp=prev.
  - If i mod Nk==0: temp=SubWord(RotWord(prev)) ^ {rcon,24'h0}; rcon<=xtime(rcon), where xtime = shift left, XOR 8'h1b on carry-out.
  - Else if Nk==8 and i mod 8==4: temp=SubWord(prev).
  - w[i] <= w[i-Nk] ^ temp; prev <= w[i]; i <= i+1.
  - i mod Nk is tracked with a wrapping counter; no divider.
- Leaving EXPAND: after writing i=4*(Nr+1)-1, go to DONE. Words computed: 40, 46 and 52 for 128, 192 and 256.
- DONE: lasts one cycle with done=1; then IDLE, ready=1.
- Start-to-done latency is 1+(4(Nr+1)-Nk)+1 edges: 42, 48 and 54.
- rk_avail = floor(words_written/4), updated registered.
  - Equals 1 (AES-128) or 2 (AES-256) after the load edge.
  - Holds Nr+1 after done until the next accepted start, which resets it to floor(Nk/4).
- Read port:
  - rd_valid=1 iff rd_round<rk_avail at the rd_en cycle.
  - Otherwise rd_valid=0 and rd_key=0; this covers rd_round>Nr and reads of incomplete rounds during EXPAND.
  - Reads are legal in any state. rd_key holds its value when rd_en=0.
- start while busy is ignored; no err, no effect.
- Reset mid-EXPAND aborts the job immediately: all reset values apply and the partial buffer is cleared.

Optional Feature:
AES_KEY_ZEROIZE_EN.
- Defined: adds input zeroize (1 bit). When zeroize=1 at an edge, in any state:
  - buffer, prev and rd_key are cleared; rk_avail=0; state goes to IDLE; no done pulse.
  - zeroize has priority over start in the same cycle.
- Undefined: the port is absent; the buffer is only cleared by reset and persists between jobs until overwritten.

Decomposition:
- Package aes_pkg holds:
  - typedef aes_word_t (32 bits), aes_blk_t (128 bits);
  - enum key_len_e, enum kx_state_e;
  - constant SBOX table; functions xtime and rot_word.
- One sub-module, aes_sbox_word: a combinational 4-byte SubWord using the SBOX table. It is instantiated once and shared by both SubWord cases.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done 42 cycles after the start edge; round 1 reads a0fafe1788542cb123a339392a6c7605; round 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6; rd_round=11 gives rd_valid=0 and rd_key=0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> nr=12; round 12 reads e98ba06f448c773c8ecc720401002202; done at 48 cycles.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> round 14 reads fe4890d1e6188d0b046df344706c631e; rk_avail=2 one cycle after start.
- Early read: during an AES-128 job, read round 3 when rk_avail first equals 4 -> rd_valid=1 with the correct key; read round 4 in that same cycle -> rd_valid=0.
- Errors and ignored starts: key_len=11 -> one err pulse, ready stays 1; start asserted mid-EXPAND -> ignored.
- Reset and zeroize: rst=0 at word 20 -> all outputs at reset values, buffer reads 0. With AES_KEY_ZEROIZE_EN, assert zeroize after done -> rk_avail=0 and a round 0 read gives rd_valid=0.
